// File: rtl/ipc_transfer_controller.sv
// Rendezvous controller for one-word IPC: sequences the process buffer bank
// (writer pid, transfer buffer, reader pid) for a single sender/receiver pair.
module ipc_transfer_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  send_req,
  input  logic                  recv_req,
  input  logic [DATA_WIDTH-1:0] pid_cur,
  input  logic [DATA_WIDTH-1:0] dest_pid,
  input  logic [DATA_WIDTH-1:0] src_pid,
  input  logic [DATA_WIDTH-1:0] send_data,
  output logic [1:0]            set_process,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  bw,
  output logic [DATA_WIDTH-1:0] buffer_data,
  output logic [DATA_WIDTH-1:0] recv_data,
  output logic                  send_ack,
  output logic                  recv_ack,
  output logic                  err,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE,
    SET_WID,
    LOAD_BUF,
    WAIT_RECV,
    WAIT_SEND,
    SET_RID,
    DELIVER,
    CLR_W,
    CLR_R
  } state_t;

  localparam logic [1:0] SP_NONE   = 2'b00;
  localparam logic [1:0] SP_READER = 2'b01;
  localparam logic [1:0] SP_WRITER = 2'b10;

  // The counter holds (cycles spent waiting - 1), so expiry is at TIMEOUT-1.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(TIMEOUT - 1);
  localparam bit                   TIMEOUT_EN = (TIMEOUT != 0);

  state_t                state;
  logic [DATA_WIDTH-1:0] s_pid;
  logic [DATA_WIDTH-1:0] d_pid;
  logic [DATA_WIDTH-1:0] x_data;
  logic [DATA_WIDTH-1:0] r_pid;
  logic [DATA_WIDTH-1:0] f_pid;
  logic                  rx_waiting;
  logic [CNT_WIDTH-1:0]  cnt;

  logic recv_match;
  logic send_match;
  logic timeout_hit;

  assign recv_match  = recv_req && (pid_cur == d_pid) &&
                       ((src_pid == '0) || (src_pid == s_pid));
  assign send_match  = send_req && (dest_pid == r_pid) &&
                       ((f_pid == '0) || (pid_cur == f_pid));
  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      s_pid      <= '0;
      d_pid      <= '0;
      x_data     <= '0;
      r_pid      <= '0;
      f_pid      <= '0;
      rx_waiting <= 1'b0;
      cnt        <= '0;
      recv_data  <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (send_req) begin
            if (pid_cur == '0 || dest_pid == '0) begin
              err <= 1'b1;
            end else begin
              s_pid  <= pid_cur;
              d_pid  <= dest_pid;
              x_data <= send_data;
              state  <= SET_WID;
            end
          end else if (recv_req) begin
            if (pid_cur == '0) begin
              err <= 1'b1;
            end else begin
              r_pid      <= pid_cur;
              f_pid      <= src_pid;
              rx_waiting <= 1'b1;
              cnt        <= '0;
              state      <= WAIT_SEND;
            end
          end
        end
        SET_WID: state <= LOAD_BUF;
        LOAD_BUF: begin
          if (rx_waiting) begin
            state <= SET_RID;
          end else begin
            cnt   <= '0;
            state <= WAIT_RECV;
          end
        end
        WAIT_RECV: begin
          cnt <= cnt + 1'b1;
          // A match in the expiry cycle takes precedence over the timeout.
          if (recv_match) begin
            state <= SET_RID;
          end else if (timeout_hit) begin
            err        <= 1'b1;
            rx_waiting <= 1'b0;
            state      <= CLR_W;
          end
        end
        WAIT_SEND: begin
          cnt <= cnt + 1'b1;
          if (send_match) begin
            s_pid  <= pid_cur;
            d_pid  <= r_pid;
            x_data <= send_data;
            state  <= SET_WID;
          end else if (timeout_hit) begin
            err        <= 1'b1;
            rx_waiting <= 1'b0;
            state      <= CLR_W;
          end
        end
        SET_RID: begin
          // Load here so recv_data is already valid while recv_ack is high.
          recv_data <= x_data;
          state     <= DELIVER;
        end
        DELIVER: begin
          rx_waiting <= 1'b0;
          state      <= CLR_W;
        end
        CLR_W:   state <= CLR_R;
        CLR_R:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    set_process = SP_NONE;
    write_data  = '0;
    bw          = 1'b0;
    buffer_data = '0;
    send_ack    = 1'b0;
    recv_ack    = 1'b0;
    case (state)
      SET_WID: begin
        set_process = SP_WRITER;
        write_data  = s_pid;
      end
      LOAD_BUF: begin
        bw          = 1'b1;
        buffer_data = x_data;
        send_ack    = 1'b1;
      end
      SET_RID: begin
        set_process = SP_READER;
        write_data  = d_pid;
      end
      DELIVER: recv_ack    = 1'b1;
      CLR_W:   set_process = SP_WRITER;
      CLR_R:   set_process = SP_READER;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
